// File: rtl/cdb_arbiter_if.sv
// Common data bus types and the arbiter's FU-side and CDB-side signal bundle.
// The slave modport is the arbiter. The master modport is the FU/ROB side.
package cdb_pkg;
  localparam int ROB_W = 5;

  typedef struct packed {
    logic             cdb_valid;
    logic [ROB_W-1:0] rob_index;
    logic [31:0]      result;
  } cdb_t;
endpackage

interface cdb_arbiter_if #(
  parameter int NUM_FU     = 3,
  parameter int FIFO_DEPTH = 4
);
  import cdb_pkg::*;

  logic                                    flush;
  logic [NUM_FU-1:0]                       fu_valid;
  cdb_t [NUM_FU-1:0]                       fu_packet;
  logic [NUM_FU-1:0]                       fu_ready;
  cdb_t                                    cdb;
  logic [NUM_FU-1:0]                       cdb_grant;
  logic [NUM_FU-1:0][$clog2(FIFO_DEPTH):0] fifo_count;

  modport master (
    output flush, fu_valid, fu_packet,
    input  fu_ready, cdb, cdb_grant, fifo_count
  );

  modport slave (
    input  flush, fu_valid, fu_packet,
    output fu_ready, cdb, cdb_grant, fifo_count
  );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB producer: per-FU result FIFOs and a one-grant-per-cycle registered broadcast.
// CDB_ARB_FIXED_PRIO_EN selects lowest-index priority; the default is round-robin.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_FU     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  cdb_arbiter_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int GW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  cdb_t              mem_q    [NUM_FU][FIFO_DEPTH];
  cdb_t              mem_d    [NUM_FU][FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q [NUM_FU];
  logic [PW-1:0]     wr_ptr_d [NUM_FU];
  logic [PW-1:0]     rd_ptr_q [NUM_FU];
  logic [PW-1:0]     rd_ptr_d [NUM_FU];
  cdb_t              cdb_q, cdb_d;
  logic [NUM_FU-1:0] grant_q, grant_d;
  logic [NUM_FU-1:0] full, empty;
  logic              win_vld;
  logic [GW-1:0]     win;
`ifndef CDB_ARB_FIXED_PRIO_EN
  logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]     scan_sel;
`endif

  always_comb begin
    full  = '0;
    empty = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      full[i]  = (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]) &&
                 (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]);
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
    end
  end

  // Ready is purely registered state, so a full FIFO stays closed even while popping.
  assign bus.fu_ready  = ~full & {NUM_FU{~rst}};
  assign bus.cdb       = cdb_q;
  assign bus.cdb_grant = grant_q;

  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_count
    assign bus.fifo_count[gi] = wr_ptr_q[gi] - rd_ptr_q[gi];
  end

  // Scan in reverse so the last hit, i.e. the first in scan order, wins.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
`ifdef CDB_ARB_FIXED_PRIO_EN
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (!empty[i]) begin
        win_vld = 1'b1;
        win     = GW'(i);
      end
    end
`else
    scan_sel = '0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      scan_sel = GW'((int'(rr_ptr_q) + k) % NUM_FU);
      if (!empty[scan_sel]) begin
        win_vld = 1'b1;
        win     = scan_sel;
      end
    end
`endif
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cdb_d    = '0;
    grant_d  = '0;
`ifndef CDB_ARB_FIXED_PRIO_EN
    rr_ptr_d = rr_ptr_q;
`endif
    if (bus.flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
      end
`ifndef CDB_ARB_FIXED_PRIO_EN
      rr_ptr_d = '0;
`endif
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (bus.fu_valid[i] && !full[i]) begin
          mem_d[i][wr_ptr_q[i][AW-1:0]] = bus.fu_packet[i];
          wr_ptr_d[i]                   = wr_ptr_q[i] + 1'b1;
        end
      end
      if (win_vld) begin
        cdb_d           = mem_q[win][rd_ptr_q[win][AW-1:0]];
        cdb_d.cdb_valid = 1'b1;
        grant_d         = NUM_FU'(1) << win;
        rd_ptr_d[win]   = rd_ptr_q[win] + 1'b1;
`ifndef CDB_ARB_FIXED_PRIO_EN
        rr_ptr_d = (win == GW'(NUM_FU - 1)) ? '0 : win + 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      cdb_q   <= '0;
      grant_q <= '0;
`ifndef CDB_ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cdb_q    <= cdb_d;
      grant_q  <= grant_d;
`ifndef CDB_ARB_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  // Storage needs no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
